// File: rtl/kws_pkg.sv
// Shared keyword-spotting front-end types: sample format, frame geometry and
// the serializer state encoding used by hamming, frame_serializer and the FFT.
package kws_pkg;

  localparam int SAMPLE_W  = 12;
  localparam int FRAME_LEN = 128;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE,
    STREAM
  } ser_state_t;

endpackage

// File: rtl/frame_bank.sv
// FRAME_LEN x WIDTH register bank: whole-frame parallel load, indexed read,
// and the full contents exposed so another bank can copy it in one cycle.
module frame_bank
  import kws_pkg::*;
#(
  parameter int WIDTH     = SAMPLE_W,
  parameter int FRAME_LEN = kws_pkg::FRAME_LEN,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data [0:FRAME_LEN-1],
  input  logic [IDX_W-1:0] rd_index,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] contents  [0:FRAME_LEN-1]
);

  logic [WIDTH-1:0] mem [0:FRAME_LEN-1];

  // Sample storage carries no reset; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (load) begin
      mem <= load_data;
    end
  end

  assign rd_data  = mem[rd_index];
  assign contents = mem;

endmodule

// File: rtl/frame_serializer.sv
// Captures parallel windowed frames and streams them one sample per
// valid/ready handshake, with a one-deep pending slot between frames.
module frame_serializer
  import kws_pkg::*;
#(
  parameter int WIDTH     = SAMPLE_W,
  parameter int FRAME_LEN = kws_pkg::FRAME_LEN,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] frame_in [0:FRAME_LEN-1],
  input  logic             frame_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             busy,
  output logic             overrun,
  output logic [7:0]       drop_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  ser_state_t       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             pend_full, pend_full_n;
  logic             act_load, act_from_pend, pend_load, drop;
  logic             xfer, last_xfer;

  logic [WIDTH-1:0] act_src      [0:FRAME_LEN-1];
  logic [WIDTH-1:0] pend_all     [0:FRAME_LEN-1];
  logic [WIDTH-1:0] act_all_unused [0:FRAME_LEN-1];
  logic [WIDTH-1:0] pend_rd_unused;

  assign out_valid = (state == STREAM);
  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & (idx == LAST_IDX);
  assign out_index = idx;
  assign out_last  = out_valid & (idx == LAST_IDX);
  assign busy      = (state == STREAM) | pend_full;

  always_comb begin
    for (int unsigned i = 0; i < FRAME_LEN; i++) begin
      act_src[i] = act_from_pend ? pend_all[i] : frame_in[i];
    end
  end

  frame_bank #(
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN),
    .IDX_W    (IDX_W)
  ) u_active (
    .clk      (clk),
    .load     (act_load),
    .load_data(act_src),
    .rd_index (idx),
    .rd_data  (out_data),
    .contents (act_all_unused)
  );

  frame_bank #(
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN),
    .IDX_W    (IDX_W)
  ) u_pending (
    .clk      (clk),
    .load     (pend_load),
    .load_data(frame_in),
    .rd_index (idx),
    .rd_data  (pend_rd_unused),
    .contents (pend_all)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      pend_full  <= 1'b0;
      overrun    <= 1'b0;
      drop_count <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      pend_full <= pend_full_n;
      if (drop) begin
        overrun <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_n       = state;
    idx_n         = idx;
    pend_full_n   = pend_full;
    act_load      = 1'b0;
    act_from_pend = 1'b0;
    pend_load     = 1'b0;
    drop          = 1'b0;

    unique case (state)
      IDLE: begin
        if (frame_valid) begin
          act_load = 1'b1;
          idx_n    = '0;
          state_n  = STREAM;
        end
      end

      STREAM: begin
        if (last_xfer) begin
          idx_n = '0;
          if (pend_full) begin
            // Pending promotes while a same-cycle arrival refills pending;
            // both banks read pre-edge values, so no sample is lost.
            act_load      = 1'b1;
            act_from_pend = 1'b1;
            if (frame_valid) begin
              pend_load = 1'b1;
            end else begin
              pend_full_n = 1'b0;
            end
          end else if (frame_valid) begin
            act_load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_n = idx + 1'b1;
          end
          if (frame_valid) begin
            if (pend_full) begin
              drop = 1'b1;
            end else begin
              pend_load   = 1'b1;
              pend_full_n = 1'b1;
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
